game_round_ctrl: RTL
====================

Name: game_round_ctrl

Overview:
- Sequences one game of the switch-matching reaction game.
- Latches the difficulty mode on start and generates a pseudo-random 8-bit target per round.
- Runs the per-round countdown from the 1 Hz tick, checks the player's switch entry on submit, and tallies the score over a fixed number of rounds.
- Sits between the 1 Hz tick generator, the switch/button inputs and the display/score logic.

Parameters:
- ROUNDS, 10, rounds per game (1..15).
- LFSR_SEED, 8'hA5, LFSR value after reset; must be non-zero.
- T_MODE0, 14, seconds per round for mod=0.
- T_MODE1, 10, seconds per round for mod=1.
- T_MODE2, 8, seconds per round for mod=2.
- T_MODE3, 6, seconds per round for mod=3.

Ports:
- clk  in  1  100 MHz system clock. One clock domain; reset is synchronous and active-low.
- rst  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- start  in  1  level; high = game enabled, low = abort/idle.
- mod  in  2  difficulty select, latched on game start.
- sec_tick  in  1  one-clk pulse per second from the tick generator.
- submit  in  1  one-clk debounced button pulse.
- sw  in  8  player entry.
- answer  out  8  current target pattern; 0 outside a round.
- time_left  out  5  seconds remaining in the current round.
- score  out  4  hits this game, saturating at 15.
- round_num  out  4  rounds completed this game.
- hit  out  1  one-clk pulse on a correct submit.
- miss  out  1  one-clk pulse on timeout.
- game_over  out  1  high in DONE.

Behaviour:
- Reset (rst=0 at a clk edge) forces the following. All in-flight state is discarded, including mid-round.
  - state=IDLE
  - answer=0, time_left=0, score=0, round_num=0, hit=0, miss=0, game_over=0
  - lfsr=LFSR_SEED, start_d=0
- LFSR: 8-bit Galois, mask 8'hB8, shifts right every clk in every state except during reset. Never 0.
- start_d registers start; a rising edge is start & ~start_d.
- IDLE:
  - score and round_num hold their last values, so the final score stays visible.
  - On a start rising edge: latch mod into mod_q, clear score and round_num, go to LOAD.
- LOAD (1 clk): answer<=lfsr; time_left<=T_MODE[mod_q]; go to PLAY.
- PLAY:
  - submit && sw==answer: go to HIT. This takes priority over a same-cycle sec_tick.
  - submit && sw!=answer: ignored, no penalty, remain in PLAY.
  - sec_tick with time_left>1: time_left-1.
  - sec_tick with time_left==1: time_left<=0, go to MISS.
- HIT (1 clk):
  - hit=1; score<=score+1, held at 15.
  - round_num+1.
  - Next state is DONE if round_num+1==ROUNDS, else LOAD.
- MISS (1 clk): miss=1; round_num+1; next-state rule identical to HIT.
- DONE:
  - game_over=1, answer=0, time_left=0; score and round_num hold.
  - Leaves only when start goes low (to IDLE). A start held high never restarts the game.
- Abort: start==0 in any state other than IDLE, with no reset, gives IDLE next clk.
  - answer=0, time_left=0, game_over=0, hit/miss=0; score and round_num hold.
- hit and miss are never high together; each is high for exactly 1 clk.
- Latency:
  - start edge to answer valid: 2 clk (IDLE→LOAD→PLAY).
  - Correct submit to hit pulse: 1 clk.
  - Round end to next answer: 2 clk.
- mod changes after game start have no effect until the next game.

Decomposition:
- Shared package: state encoding, one of IDLE/LOAD/PLAY/HIT/MISS/DONE (3 bits); function mapping a 2-bit mode to seconds from the T_MODE parameters.
- One sub-module, lfsr8 (ports clk, rst, seed, q), is natural and reusable by other game logic.
- The FSM, countdown and scoring stay in game_round_ctrl.

Test Plan:
- Reset then start↑ with mod=2 → PLAY within 2 clk; time_left=8; answer equals lfsr value sampled in LOAD (non-zero).
- In PLAY, pulse submit with sw=answer → hit=1 for 1 clk; score 0→1; round_num 0→1; new answer 2 clk later; time_left reloaded to 8.
- mod=3, no submits, 6 sec_ticks → time_left 6,5,…,1,0; miss pulse 1 clk after the 6th tick; score unchanged; round_num=1.
- Same cycle: submit with correct sw and sec_tick while time_left==1 → hit, not miss; score+1.
- ROUNDS=10, all correct submits → game_over=1 after the 10th hit, score=10. Holding start high keeps DONE; start low → IDLE with score still 10; next start↑ → score=0.
- Mid-round checks:
  - start low → IDLE next clk; answer=0; score held.
  - rst=0 mid-round, sampled at clk → all outputs 0 next edge.
  - rst=0 for a sub-cycle glitch not sampled at clk → no effect.

Source files
------------

// File: rtl/game_round_ctrl_pkg.sv
// Shared types and helpers for the switch-matching reaction game.
package game_round_ctrl_pkg;

    // Round sequencer states
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_PLAY = 3'd2,
        ST_HIT  = 3'd3,
        ST_MISS = 3'd4,
        ST_DONE = 3'd5
    } round_state_e;

    // Galois feedback taps for the 8-bit target generator
    localparam logic [7:0] LFSR_MASK = 8'hB8;

    // One right shift of the Galois LFSR; a non-zero state never reaches zero
    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        lfsr_next = (cur >> 1) ^ (cur[0] ? LFSR_MASK : 8'h00);
    endfunction

    // Seconds per round for a given difficulty mode
    function automatic logic [4:0] mode_seconds(
        input logic [1:0] m,
        input logic [4:0] t0,
        input logic [4:0] t1,
        input logic [4:0] t2,
        input logic [4:0] t3
    );
        case (m)
            2'd0:    mode_seconds = t0;
            2'd1:    mode_seconds = t1;
            2'd2:    mode_seconds = t2;
            2'd3:    mode_seconds = t3;
            default: mode_seconds = t0;
        endcase
    endfunction

endpackage

// File: rtl/game_round_ctrl_lfsr8.sv
// Free-running 8-bit Galois LFSR, reloaded with seed while reset is low.
module lfsr8
    import game_round_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] seed,
    output logic [7:0] q
);

    logic [7:0] q_r;

    // Shift once per clock; reload the seed during reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            q_r <= seed;
        end else begin
            q_r <= lfsr_next(q_r);
        end
    end

    assign q = q_r;

endmodule

// File: rtl/game_round_ctrl.sv
// Sequences one game: mode latch, per-round target, countdown, scoring.
module game_round_ctrl
    import game_round_ctrl_pkg::*;
#(
    parameter int         ROUNDS    = 10,
    parameter logic [7:0] LFSR_SEED = 8'hA5,
    parameter int         T_MODE0   = 14,
    parameter int         T_MODE1   = 10,
    parameter int         T_MODE2   = 8,
    parameter int         T_MODE3   = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] mod,
    input  logic       sec_tick,
    input  logic       submit,
    input  logic [7:0] sw,
    output logic [7:0] answer,
    output logic [4:0] time_left,
    output logic [3:0] score,
    output logic [3:0] round_num,
    output logic       hit,
    output logic       miss,
    output logic       game_over
);

    localparam logic [3:0] ROUNDS_C = 4'(ROUNDS);
    localparam logic [4:0] T0_C     = 5'(T_MODE0);
    localparam logic [4:0] T1_C     = 5'(T_MODE1);
    localparam logic [4:0] T2_C     = 5'(T_MODE2);
    localparam logic [4:0] T3_C     = 5'(T_MODE3);

    round_state_e state_r, state_s;
    logic       start_d_r;
    logic [1:0] mod_q_r, mod_q_s;
    logic [7:0] answer_r, answer_s;
    logic [4:0] time_left_r, time_left_s;
    logic [3:0] score_r, score_s;
    logic [3:0] round_num_r, round_num_s;
    logic       hit_r, hit_s;
    logic       miss_r, miss_s;
    logic       game_over_r, game_over_s;
    logic [7:0] lfsr_q_s;
    logic       start_rise_s;
    logic       last_round_s;
    logic [4:0] load_secs_s;
    logic [3:0] score_inc_s;

    lfsr8 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .seed (LFSR_SEED),
        .q    (lfsr_q_s)
    );

    assign start_rise_s = start & ~start_d_r;
    assign last_round_s = ((round_num_r + 4'd1) == ROUNDS_C);
    assign load_secs_s  = mode_seconds(mod_q_r, T0_C, T1_C, T2_C, T3_C);
    assign score_inc_s  = (score_r == 4'd15) ? 4'd15 : (score_r + 4'd1);

    // Next-state and next-output logic; abort (start low) overrides every active state
    always_comb begin
        state_s     = state_r;
        mod_q_s     = mod_q_r;
        answer_s    = answer_r;
        time_left_s = time_left_r;
        score_s     = score_r;
        round_num_s = round_num_r;
        hit_s       = 1'b0;
        miss_s      = 1'b0;
        game_over_s = game_over_r;

        if ((state_r != ST_IDLE) && !start) begin
            state_s     = ST_IDLE;
            answer_s    = 8'd0;
            time_left_s = 5'd0;
            game_over_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    answer_s    = 8'd0;
                    time_left_s = 5'd0;
                    game_over_s = 1'b0;
                    if (start_rise_s) begin
                        mod_q_s     = mod;
                        score_s     = 4'd0;
                        round_num_s = 4'd0;
                        state_s     = ST_LOAD;
                    end else begin
                        state_s     = ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    answer_s    = lfsr_q_s;
                    time_left_s = load_secs_s;
                    state_s     = ST_PLAY;
                end
                ST_PLAY: begin
                    // A correct entry wins over a tick arriving in the same cycle
                    if (submit && (sw == answer_r)) begin
                        hit_s   = 1'b1;
                        state_s = ST_HIT;
                    end else if (sec_tick) begin
                        if (time_left_r > 5'd1) begin
                            time_left_s = time_left_r - 5'd1;
                        end else begin
                            time_left_s = 5'd0;
                            miss_s      = 1'b1;
                            state_s     = ST_MISS;
                        end
                    end else begin
                        state_s = ST_PLAY;
                    end
                end
                ST_HIT, ST_MISS: begin
                    score_s     = (state_r == ST_HIT) ? score_inc_s : score_r;
                    round_num_s = round_num_r + 4'd1;
                    if (last_round_s) begin
                        state_s     = ST_DONE;
                        game_over_s = 1'b1;
                        answer_s    = 8'd0;
                        time_left_s = 5'd0;
                    end else begin
                        state_s     = ST_LOAD;
                    end
                end
                ST_DONE: begin
                    // Only a low start releases DONE (handled by the abort path)
                    state_s     = ST_DONE;
                    game_over_s = 1'b1;
                    answer_s    = 8'd0;
                    time_left_s = 5'd0;
                end
                default: begin
                    state_s     = ST_IDLE;
                    answer_s    = 8'd0;
                    time_left_s = 5'd0;
                    game_over_s = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            start_d_r   <= 1'b0;
            mod_q_r     <= 2'd0;
            answer_r    <= 8'd0;
            time_left_r <= 5'd0;
            score_r     <= 4'd0;
            round_num_r <= 4'd0;
            hit_r       <= 1'b0;
            miss_r      <= 1'b0;
            game_over_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            start_d_r   <= start;
            mod_q_r     <= mod_q_s;
            answer_r    <= answer_s;
            time_left_r <= time_left_s;
            score_r     <= score_s;
            round_num_r <= round_num_s;
            hit_r       <= hit_s;
            miss_r      <= miss_s;
            game_over_r <= game_over_s;
        end
    end

    assign answer    = answer_r;
    assign time_left = time_left_r;
    assign score     = score_r;
    assign round_num = round_num_r;
    assign hit       = hit_r;
    assign miss      = miss_r;
    assign game_over = game_over_r;

endmodule
